add_split_pipe: RTL and testbench
=================================

# add_split_pipe

Pipelined, parametrised wide adder/subtractor. It splits a Y_WIDTH-bit add or subtract into CHUNK-bit slices and registers the carry between slices, so no combinational carry chain is longer than CHUNK+1 bits. It sits in datapaths where wide `$add`/`$sub` would otherwise break timing. It carries a valid/ready stream with full backpressure, supports signed or unsigned operands, and selects add or subtract per transaction.

## Interface
- A_WIDTH, 32: operand A width.
- B_WIDTH, 32: operand B width.
- Y_WIDTH, 64: result width; result is modulo 2^Y_WIDTH.
- CHUNK, 16: bits per pipeline slice; 1 ≤ CHUNK ≤ Y_WIDTH.
- SIGNED, 0: 1 = sign-extend A and B; 0 = zero-extend.
- Derived N = ceil(Y_WIDTH/CHUNK) slices; W = N*CHUNK internal width.

Ports:
- clk  in  1  clock; all state on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts input this cycle.
- in_a  in  A_WIDTH  operand A.
- in_b  in  B_WIDTH  operand B.
- in_sub  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- out_y  out  Y_WIDTH  result.

## Operation
- An input is accepted when in_valid && in_ready.
- Operand prep:
  - Extend A and B to W bits (sign-extend if SIGNED, else zero-extend); truncate operands wider than W.
  - If in_sub, invert the extended B and set slice-0 carry-in to 1; otherwise carry-in is 0.
- Slice k (k = 0..N−1):
  - Computes {c_k, s_k} = a_k + b_k + c_{k−1} in stage k.
  - c_{−1} is the carry-in above.
  - c_{N−1} is discarded.
- Skew and deskew:
  - Slice k operands are delayed k stages before use.
  - Slice k sums are delayed N−1−k stages afterward.
  - All slices of one transaction emerge together.
- out_y = s[Y_WIDTH−1:0]. Bits W−1..Y_WIDTH are computed and dropped.
- Stall rule: a single advance enable, en = !out_valid || out_ready.
  - All stage registers (data, carry, valid) load only when en = 1.
  - in_ready = en.
- Each stage has its own valid bit, and bubbles travel with the data.
- Output order equals input order. No transaction is dropped or duplicated.
- Holding rule: while out_valid && !out_ready, out_y and out_valid hold stable.
- Reset:
  - All valid bits clear asynchronously, so out_valid = 0 and out_y = 0.
  - All data and carry registers reset to 0.
  - in_ready = 1 once reset_n is high.
- Reset mid-operation discards every in-flight transaction. Nothing stale is emitted after release.
- N = 1: a single registered add; no skew or deskew registers are built.

## Timing
- Latency: a transaction accepted at edge t appears on out_y/out_valid after edge t+N, assuming no stall.
- Throughput: one transaction per cycle when out_ready = 1.
- Without the skid buffer, in_ready depends combinationally on out_ready; this is the only combinational path from input to output.
- Longest combinational path: one CHUNK-bit add plus carry-in plus the sub-inversion mux in stage 0.
- Simultaneous accept and emit in the same cycle is legal and required at full rate.

## Configuration
- ADD_SPLIT_PIPE_SKID_EN defined:
  - A 2-entry skid buffer follows the last stage.
  - en is driven by the skid buffer's registered not-full flag.
  - in_ready has no combinational path from out_ready.
  - Latency becomes N+1.
  - Throughput stays at 1 per cycle.
  - The skid buffer resets empty.
- Not defined: behaviour is exactly as above, with latency N and combinational in_ready.

## Structure
- Shared package add_split_pkg holds:
  - function ceil_div(a,b) for N;
  - constants OP_ADD = 1'b0 and OP_SUB = 1'b1;
  - function ext_width(Y_WIDTH, CHUNK) returning W.
- Top: add_split_pipe.
  - Generate loop over slices.
  - Skew/deskew shift registers inferred inline.
- Natural sub-module: add_split_pipe_skid (2-entry valid/ready skid buffer), instantiated only under ADD_SPLIT_PIPE_SKID_EN.

## Test plan
Defaults apply unless stated (Y_WIDTH = 64, CHUNK = 16, N = 4).
- Unsigned full carry ripple: A_WIDTH = B_WIDTH = 64, A = 0xFFFF_FFFF_FFFF_FFFF, B = 1, add → out_y = 0 exactly 4 cycles later (5 with SKID_EN).
- Subtract with borrow: A = 0, B = 1, in_sub = 1 → out_y = 0xFFFF_FFFF_FFFF_FFFF. Then A = 0x1_0000, B = 1 → 0xFFFF.
- Signed extension: SIGNED = 1, A_WIDTH = 8, A = 0x80, B_WIDTH = 32, B = 1, add → 0xFFFF_FFFF_FFFF_FF81. Repeat with Y_WIDTH = 40 (N = 3, partial top slice) → 0xFF_FFFF_FF81.
- Full rate: 8 back-to-back random add/sub transactions with out_ready = 1 → 8 results on consecutive cycles, in order, each matching a reference model mod 2^Y_WIDTH.
- Backpressure: stream 10 transactions and drop out_ready for cycles 5–7 → in_ready = 0 in the same cycles (non-skid), out_y stable while stalled, all 10 results delivered in order.
- Reset mid-flight: 3 transactions in flight, pulse reset_n low for 2 cycles → out_valid = 0 immediately, in_ready = 1 after release, no output until a new transaction, which has correct latency.

Source files
------------

// File: rtl/add_split_pkg.sv
// add_split_pkg: shared constants and elaboration helpers for the split-carry
// adder pipeline (add_split_pipe and its skid buffer).
package add_split_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Integer ceiling division, used to size the slice count.
   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // Internal datapath width: whole number of slices covering y_width.
   function automatic int ext_width(input int y_width, input int chunk);
      return ceil_div(y_width, chunk) * chunk;
   endfunction

endpackage

// File: rtl/add_split_pipe_skid.sv
// add_split_pipe_skid: 2-entry valid/ready skid buffer. The upstream ready is a
// registered not-full flag, so it never depends combinationally on out_ready.
module add_split_pipe_skid
   import add_split_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic [1:0]       count_nxt;
   logic             not_full_q;
   logic             push;
   logic             pop;

   assign push      = in_valid && not_full_q;
   assign pop       = out_valid && out_ready;
   assign count_nxt = count + {1'b0, push} - {1'b0, pop};

   // Storage, pointers, occupancy and the registered not-full flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the entries are reset too so out_data reads 0 straight after reset.
         mem[0]     <= '0;
         mem[1]     <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= 2'd0;
         not_full_q <= 1'b1;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values.
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count      <= count_nxt;
         not_full_q <= (count_nxt != 2'd2);
      end
   end

   assign in_ready  = not_full_q;
   assign out_valid = (count != 2'd0);
   assign out_data  = mem[rd_ptr];

endmodule

// File: rtl/add_split_pipe.sv
// add_split_pipe: pipelined wide add/subtract. The Y_WIDTH-bit operation is cut
// into CHUNK-bit slices with the carry registered between slices; operands are
// skewed into the pipe and sums deskewed out so a transaction leaves intact.
// Optional build macro ADD_SPLIT_PIPE_SKID_EN adds a 2-entry output skid buffer
// (latency N+1, in_ready registered). Without it latency is N and in_ready is
// combinational on out_ready.
module add_split_pipe
   import add_split_pkg::*;
#(
   parameter int A_WIDTH = 32,
   parameter int B_WIDTH = 32,
   parameter int Y_WIDTH = 64,
   parameter int CHUNK   = 16,
   parameter int SIGNED  = 0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [A_WIDTH-1:0] in_a,
   input  logic [B_WIDTH-1:0] in_b,
   input  logic               in_sub,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [Y_WIDTH-1:0] out_y
);

   localparam int N = ceil_div(Y_WIDTH, CHUNK);
   localparam int W = ext_width(Y_WIDTH, CHUNK);

   logic         en;
   logic [N-1:0] v_q;
   logic [W-1:0] a_ext;
   logic [W-1:0] b_ext;
   logic [W-1:0] b_op;
   logic         cin0;
   logic [W-1:0] y_full;

   // Extend operands to W bits and fold subtraction into ~B plus carry-in.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      a_ext = W'(in_a);
      b_ext = W'(in_b);
      if (SIGNED != 0) begin
         a_ext = W'($signed(in_a));
         b_ext = W'($signed(in_b));
      end
      b_op = (in_sub == OP_ADD) ? b_ext : ~b_ext;
      cin0 = (in_sub == OP_SUB);
   end

   // Per-stage valid bits; bubbles shift along with the data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v_q <= '0;
      end else if (en) begin
         v_q[0] <= in_valid;
         for (int i = 1; i < N; i++) begin
            v_q[i] <= v_q[i-1];
         end
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_slice
      logic [CHUNK-1:0] a_k;
      logic [CHUNK-1:0] b_k;
      logic             cin_k;
      logic [CHUNK-1:0] s_k;
      logic [CHUNK-1:0] s_q [N-k];

      if (k == 0) begin : g_head
         assign a_k   = a_ext[CHUNK-1:0];
         assign b_k   = b_op[CHUNK-1:0];
         assign cin_k = cin0;
      end else begin : g_skew
         logic [CHUNK-1:0] a_d [k];
         logic [CHUNK-1:0] b_d [k];
         logic             c_q;

         // Delay this slice's operands k stages and capture the lower slice's carry.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               for (int i = 0; i < k; i++) begin
                  a_d[i] <= '0;
                  b_d[i] <= '0;
               end
               c_q <= 1'b0;
            end else if (en) begin
               a_d[0] <= a_ext[k*CHUNK +: CHUNK];
               b_d[0] <= b_op[k*CHUNK +: CHUNK];
               for (int i = 1; i < k; i++) begin
                  a_d[i] <= a_d[i-1];
                  b_d[i] <= b_d[i-1];
               end
               c_q <= g_slice[k-1].g_carry.c_out;
            end
         end

         assign a_k   = a_d[k-1];
         assign b_k   = b_d[k-1];
         assign cin_k = c_q;
      end

      if (k < N-1) begin : g_carry
         logic c_out;
         assign {c_out, s_k} = (CHUNK+1)'(a_k) + (CHUNK+1)'(b_k) + (CHUNK+1)'(cin_k);
      end else begin : g_top
         // Carry out of the top slice falls off the modulo-2^W result.
         assign s_k = a_k + b_k + CHUNK'(cin_k);
      end

      // Register this slice's sum, then hold it back until the top slice catches up.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            for (int i = 0; i < N-k; i++) begin
               s_q[i] <= '0;
            end
         end else if (en) begin
            s_q[0] <= s_k;
            for (int i = 1; i < N-k; i++) begin
               s_q[i] <= s_q[i-1];
            end
         end
      end

      assign y_full[k*CHUNK +: CHUNK] = s_q[N-1-k];
   end

`ifdef ADD_SPLIT_PIPE_SKID_EN
   logic skid_ready;

   assign en = skid_ready;

   add_split_pipe_skid #(
      .WIDTH(Y_WIDTH)
   ) u_skid (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (v_q[N-1]),
      .in_ready  (skid_ready),
      .in_data   (y_full[Y_WIDTH-1:0]),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_y)
   );
`else
   assign en        = !v_q[N-1] || out_ready;
   assign out_valid = v_q[N-1];
   assign out_y     = y_full[Y_WIDTH-1:0];
`endif

   assign in_ready = en;

endmodule

// File: tb/tb_add_split_pipe.sv
// tb_add_split_pipe: directed self-checking bench for add_split_pipe. A 64-bit
// unsigned instance covers carry ripple, borrow, full rate, backpressure and
// reset; two signed 8+32-bit instances (Y=64 and Y=40) cover sign extension.
module tb_add_split_pipe;

`ifdef ADD_SPLIT_PIPE_SKID_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif
   localparam int LAT64 = 4 + EXTRA;
   localparam int LAT40 = 3 + EXTRA;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic        in_sub;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_y;

   logic        s_valid;
   logic [7:0]  s_a;
   logic [31:0] s_b;
   logic        s_sub;
   logic        s_out_ready = 1'b1;
   logic        s64_in_ready;
   logic        s64_out_valid;
   logic [63:0] s64_y;
   logic        s40_in_ready;
   logic        s40_out_valid;
   logic [39:0] s40_y;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          n_stall = 0;
   bit          stall_on = 1'b0;
   int          s_lo = 0;
   int          s_hi = 0;
   bit          hold_pending = 1'b0;
   logic [63:0] held_y;
   logic [63:0] exp_q [$];
   int          t_q [$];

   add_split_pipe #(
      .A_WIDTH(64), .B_WIDTH(64), .Y_WIDTH(64), .CHUNK(16), .SIGNED(0)
   ) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
      .out_ready(out_ready), .out_y(out_y)
   );

   add_split_pipe #(
      .A_WIDTH(8), .B_WIDTH(32), .Y_WIDTH(64), .CHUNK(16), .SIGNED(1)
   ) dut_s64 (
      .clk(clk), .reset_n(reset_n), .in_valid(s_valid), .in_ready(s64_in_ready),
      .in_a(s_a), .in_b(s_b), .in_sub(s_sub), .out_valid(s64_out_valid),
      .out_ready(s_out_ready), .out_y(s64_y)
   );

   add_split_pipe #(
      .A_WIDTH(8), .B_WIDTH(32), .Y_WIDTH(40), .CHUNK(16), .SIGNED(1)
   ) dut_s40 (
      .clk(clk), .reset_n(reset_n), .in_valid(s_valid), .in_ready(s40_in_ready),
      .in_a(s_a), .in_b(s_b), .in_sub(s_sub), .out_valid(s40_out_valid),
      .out_ready(s_out_ready), .out_y(s40_y)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Downstream ready: low only inside the programmed stall window.
   always @(posedge clk) begin
      #1;
      out_ready = !(stall_on && cyc >= s_lo && cyc <= s_hi);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one transaction until accepted (bounded), queue its reference result.
   task automatic send(input logic [63:0] a, input logic [63:0] b, input logic sub);
      bit got = 1'b0;
      in_a     = a;
      in_b     = b;
      in_sub   = sub;
      in_valid = 1'b1;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (got) exp_q.push_back(sub ? a - b : a + b);
      check("send_accept", 64'(got), 64'd1);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
      tick();
      tick();
      check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   // Signed vector on both signed instances, checking value and latency.
   task automatic signed_vec(input string tag, input logic [7:0] a, input logic [31:0] b,
                             input logic sub, input logic [63:0] e64, input logic [39:0] e40);
      int c0;
      bit got64 = 1'b0;
      bit got40 = 1'b0;
      s_a     = a;
      s_b     = b;
      s_sub   = sub;
      s_valid = 1'b1;
      c0      = cyc;
      tick();
      s_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (s64_out_valid && !got64) begin
            check({tag, "_lat64"}, 64'(cyc - c0), 64'(LAT64));
            check({tag, "_y64"}, s64_y, e64);
            got64 = 1'b1;
         end
         if (s40_out_valid && !got40) begin
            check({tag, "_lat40"}, 64'(cyc - c0), 64'(LAT40));
            check({tag, "_y40"}, 64'(s40_y), 64'(e40));
            got40 = 1'b1;
         end
         tick();
      end
      check({tag, "_seen64"}, 64'(got64), 64'd1);
      check({tag, "_seen40"}, 64'(got40), 64'd1);
   endtask

   // Output monitor: scoreboard order, hold stability, ready rule.
   always @(negedge clk) begin
      if (!reset_n) begin
         hold_pending = 1'b0;
      end else begin
         if (hold_pending) begin
            check("hold_y", out_y, held_y);
            check("hold_valid", 64'(out_valid), 64'd1);
         end
`ifndef ADD_SPLIT_PIPE_SKID_EN
         check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
`endif
         if (out_valid && !out_ready) n_stall++;
         hold_pending = out_valid && !out_ready;
         held_y       = out_y;
         if (out_valid && out_ready) begin
            t_q.push_back(cyc);
            check("expected_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("result", out_y, exp_q.pop_front());
         end
      end
   end

   initial begin
      int          c0;
      logic [63:0] ra;
      logic [63:0] rb;
      logic        rs;

      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      in_sub   = 1'b0;
      s_valid  = 1'b0;
      s_a      = '0;
      s_b      = '0;
      s_sub    = 1'b0;

      #1;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_out_y", out_y, 64'd0);
      check("reset_s64_valid", 64'(s64_out_valid), 64'd0);
      tick();
      tick();
      reset_n = 1'b1;
      #1;
      check("release_in_ready", 64'(in_ready), 64'd1);

      // Carry ripples through every slice.
      t_q.delete();
      tick();
      c0 = cyc;
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      drain("ripple");
      check("ripple_count", 64'(t_q.size()), 64'd1);
      if (t_q.size() >= 1) check("ripple_latency", 64'(t_q[0] - c0), 64'(LAT64));

      // Borrow across all slices, then across one slice boundary.
      t_q.delete();
      send(64'd0, 64'd1, 1'b1);
      send(64'h1_0000, 64'd1, 1'b1);
      drain("sub");
      check("sub_count", 64'(t_q.size()), 64'd2);

      // Full rate: eight back-to-back mixed transactions.
      t_q.delete();
      c0 = cyc;
      for (int i = 0; i < 8; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         rs = 1'($urandom_range(0, 1));
         send(ra, rb, rs);
      end
      check("fr_accept_cycles", 64'(cyc - c0), 64'd8);
      drain("fullrate");
      check("fr_count", 64'(t_q.size()), 64'd8);
      for (int i = 0; i < t_q.size(); i++) begin
         check("fr_timing", 64'(t_q[i] - c0), 64'(LAT64 + i));
      end

      // Backpressure: downstream stalls for cycles 5..7 of a 10-deep stream.
      t_q.delete();
      n_stall  = 0;
      c0       = cyc;
      s_lo     = c0 + 5;
      s_hi     = c0 + 7;
      stall_on = 1'b1;
      for (int i = 0; i < 10; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         send(ra, rb, 1'(i % 2));
      end
`ifndef ADD_SPLIT_PIPE_SKID_EN
      check("bp_accept_cycles", 64'(cyc - c0), 64'd13);
`endif
      drain("backpressure");
      stall_on = 1'b0;
      check("bp_count", 64'(t_q.size()), 64'd10);
      check("bp_stall_cycles", 64'(n_stall), 64'd3);

      // Reset with three transactions in flight.
      t_q.delete();
      send(64'd11, 64'd22, 1'b0);
      send(64'd33, 64'd44, 1'b0);
      send(64'd55, 64'd66, 1'b1);
      for (int i = 0; i < 10 && !out_valid; i++) tick();
      check("rst_had_output", 64'(out_valid), 64'd1);
      reset_n = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_y", out_y, 64'd0);
      exp_q.delete();
      tick();
      tick();
      reset_n = 1'b1;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      repeat (8) tick();
      check("rst_no_stale", 64'(t_q.size()), 64'd0);
      c0 = cyc;
      send(64'd5, 64'd7, 1'b0);
      drain("post_reset");
      check("post_reset_count", 64'(t_q.size()), 64'd1);
      if (t_q.size() >= 1) check("post_reset_latency", 64'(t_q[0] - c0), 64'(LAT64));

      // Sign extension, including the partial top slice of the 40-bit instance.
      signed_vec("sx_neg", 8'h80, 32'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FF81, 40'hFF_FFFF_FF81);
      signed_vec("sx_m1", 8'h7F, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_0000_007E, 40'h00_0000_007E);
      signed_vec("sx_sub", 8'h05, 32'h10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF5, 40'hFF_FFFF_FFF5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
